// File: rtl/hazard_pkg.sv
// Shared types and select encodings for the hazard/forwarding controller.
package hazard_pkg;
  localparam int MAX_ADDR_W = 8;

  localparam logic [1:0] FWD_RF   = 2'd0;
  localparam logic [1:0] FWD_WB   = 2'd1;
  localparam logic [1:0] FWD_MEM1 = 2'd2;

  typedef struct packed {
    logic                  valid;
    logic                  regWrite;
    logic                  memRead;
    logic [MAX_ADDR_W-1:0] dest;
  } sb_entry_t;
endpackage

// File: rtl/hazard_match.sv
// Youngest-match priority encoder over the in-flight producer scoreboard.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int START = 0,
  parameter int POS_W = 2
) (
  input  sb_entry_t [DEPTH-1:0]  sb,
  input  logic [MAX_ADDR_W-1:0]  addr,
  input  logic                   used,
  output logic                   hit,
  output logic [POS_W-1:0]       pos,
  output logic                   isLoad
);
  // Scan oldest to youngest so the lowest position wins.
  always_comb begin
    hit    = 1'b0;
    pos    = '0;
    isLoad = 1'b0;
    for (int k = DEPTH-1; k >= START; k--) begin
      if (used && sb[k].valid && sb[k].regWrite && sb[k].dest != '0 && sb[k].dest == addr) begin
        hit    = 1'b1;
        pos    = POS_W'(k);
        isLoad = sb[k].memRead;
      end
    end
  end
endmodule

// File: rtl/hazard_forwarding_unit.sv
// Hazard detection, EX/ID forwarding selects and stall counter for a pipeline with L MEM stages.
module hazard_forwarding_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_LATENCY = 1,
  parameter int SEL_W       = $clog2(MEM_LATENCY+2),
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] addressRsId,
  input  logic [REG_ADDR_W-1:0] addressRtId,
  input  logic                  useRsId,
  input  logic                  useRtId,
  input  logic [REG_ADDR_W-1:0] destId,
  input  logic                  regWriteId,
  input  logic                  memReadId,
  input  logic                  branchId,
  input  logic                  flushId,
  output logic                  hazard,
  output logic [SEL_W-1:0]      forwardingMux0Ex,
  output logic [SEL_W-1:0]      forwardingMux1Ex,
  output logic [1:0]            forwardingBranch0Id,
  output logic [1:0]            forwardingBranch1Id,
  output logic [CNT_W-1:0]      stallCount
);
  localparam int DEPTH = MEM_LATENCY + 2;
  localparam logic [SEL_W-1:0] WB_SEL  = SEL_W'(MEM_LATENCY + 1);
  localparam logic [SEL_W-1:0] LAT_SEL = SEL_W'(MEM_LATENCY);

  sb_entry_t [DEPTH-1:0]  sb;
  logic [REG_ADDR_W-1:0]  exRs, exRt;
  logic                   exUseRs, exUseRt;

  // Sources 0/1 are the EX operands (scan from MEM1), 2/3 the ID operands (scan from EX).
  logic [3:0][MAX_ADDR_W-1:0] srcAddr;
  logic [3:0]                 srcUse, hit, isLoad;
  logic [3:0][SEL_W-1:0]      pos;

  assign srcAddr[0] = MAX_ADDR_W'(exRs);
  assign srcAddr[1] = MAX_ADDR_W'(exRt);
  assign srcAddr[2] = MAX_ADDR_W'(addressRsId);
  assign srcAddr[3] = MAX_ADDR_W'(addressRtId);
  assign srcUse[0]  = sb[0].valid & exUseRs;
  assign srcUse[1]  = sb[0].valid & exUseRt;
  assign srcUse[2]  = useRsId;
  assign srcUse[3]  = useRtId;

  for (genvar g = 0; g < 4; g++) begin : gMatch
    hazard_match #(.DEPTH(DEPTH), .START(g < 2 ? 1 : 0), .POS_W(SEL_W)) uMatch (
      .sb(sb), .addr(srcAddr[g]), .used(srcUse[g]),
      .hit(hit[g]), .pos(pos[g]), .isLoad(isLoad[g])
    );
  end

  function automatic logic [SEL_W-1:0] exSel(input logic h, input logic ld, input logic [SEL_W-1:0] p);
    if (!h)          return '0;
    if (p == WB_SEL) return SEL_W'(FWD_WB);
    if (ld)          return '0;  // load data only exists after WB
    return p + SEL_W'(1);
  endfunction

  function automatic logic [1:0] idSel(input logic h, input logic ld, input logic [SEL_W-1:0] p);
    if (h && p == WB_SEL)              return FWD_WB;
    if (h && p == SEL_W'(1) && !ld)    return FWD_MEM1;
    return FWD_RF;
  endfunction

  function automatic logic srcStall(input logic h, input logic ld, input logic br,
                                    input logic [SEL_W-1:0] p);
    return h && ((ld && p < LAT_SEL) ||
                 (br && p == '0) ||
                 (br && ld && p != '0 && p <= LAT_SEL));
  endfunction

  assign forwardingMux0Ex    = exSel(hit[0], isLoad[0], pos[0]);
  assign forwardingMux1Ex    = exSel(hit[1], isLoad[1], pos[1]);
  assign forwardingBranch0Id = idSel(hit[2], isLoad[2], pos[2]);
  assign forwardingBranch1Id = idSel(hit[3], isLoad[3], pos[3]);

  // A squashed instruction never stalls; flush takes precedence.
  assign hazard = ~flushId & (srcStall(hit[2], isLoad[2], branchId, pos[2]) |
                              srcStall(hit[3], isLoad[3], branchId, pos[3]));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sb         <= '0;
      exRs       <= '0;
      exRt       <= '0;
      exUseRs    <= 1'b0;
      exUseRt    <= 1'b0;
      stallCount <= '0;
    end else begin
      for (int k = DEPTH-1; k > 0; k--) sb[k] <= sb[k-1];
      if (hazard || flushId) begin
        sb[0]   <= '0;
        exUseRs <= 1'b0;
        exUseRt <= 1'b0;
      end else begin
        sb[0]   <= '{valid: 1'b1, regWrite: regWriteId, memRead: memReadId,
                     dest: MAX_ADDR_W'(destId)};
        exUseRs <= useRsId;
        exUseRt <= useRtId;
      end
      exRs <= addressRsId;
      exRt <= addressRtId;
      if (hazard && stallCount != '1) stallCount <= stallCount + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_forwarding_unit.sv
// Directed scoreboard bench: L=1/CNT_W=4 and L=2/CNT_W=16 instances share the ID stimulus.
module tb_hazard_forwarding_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [4:0] rs = '0, rt = '0, dst = '0;
  logic ur = 0, ut = 0, rw = 0, mr = 0, br = 0, fl = 0;

  logic       h1; logic [1:0] m0a, m1a, b0a, b1a; logic [3:0]  sc1;
  logic       h2; logic [1:0] m0b, m1b, b0b, b1b; logic [15:0] sc2;

  always #5 clk = ~clk;

  hazard_forwarding_unit #(.REG_ADDR_W(5), .MEM_LATENCY(1), .CNT_W(4)) dut1 (
    .clk(clk), .reset(reset), .addressRsId(rs), .addressRtId(rt), .useRsId(ur), .useRtId(ut),
    .destId(dst), .regWriteId(rw), .memReadId(mr), .branchId(br), .flushId(fl),
    .hazard(h1), .forwardingMux0Ex(m0a), .forwardingMux1Ex(m1a),
    .forwardingBranch0Id(b0a), .forwardingBranch1Id(b1a), .stallCount(sc1));

  hazard_forwarding_unit #(.REG_ADDR_W(5), .MEM_LATENCY(2), .CNT_W(16)) dut2 (
    .clk(clk), .reset(reset), .addressRsId(rs), .addressRtId(rt), .useRsId(ur), .useRtId(ut),
    .destId(dst), .regWriteId(rw), .memReadId(mr), .branchId(br), .flushId(fl),
    .hazard(h2), .forwardingMux0Ex(m0b), .forwardingMux1Ex(m1b),
    .forwardingBranch0Id(b0b), .forwardingBranch1Id(b1b), .stallCount(sc2));

  localparam logic [5:0] UR = 6'b100000, UT = 6'b010000, RW = 6'b001000,
                         MR = 6'b000100, BR = 6'b000010, FL = 6'b000001;
  localparam logic [5:0] MH = 6'd1, M0 = 6'd2, M1 = 6'd4, B0 = 6'd8, B1 = 6'd16, MS = 6'd32,
                         ALL = 6'd63;

  typedef struct {
    string    tag;
    bit       d2;
    bit [5:0] mask;
    bit       h;
    bit [1:0] m0, m1, b0, b1;
    int       sc;
  } exp_t;

  exp_t expQ[$];
  exp_t e;
  int passCnt = 0, totalCnt = 0;

  logic [4:0] nRs = '0, nRt = '0, nDst = '0;
  logic [5:0] nF = '0;
  logic       nReset = 1'b0;

  task automatic chk(input string tag, input string f, input int act, input int want);
    totalCnt++;
    if (act == want) passCnt++;
    else $display("FAIL %s.%s: got %0d expected %0d", tag, f, act, want);
  endtask

  // Monitor: one expectation per cycle, compared at the falling edge.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      if (e.mask[0]) chk(e.tag, "hazard",    e.d2 ? int'(h2)  : int'(h1),  int'(e.h));
      if (e.mask[1]) chk(e.tag, "fwdMux0Ex", e.d2 ? int'(m0b) : int'(m0a), int'(e.m0));
      if (e.mask[2]) chk(e.tag, "fwdMux1Ex", e.d2 ? int'(m1b) : int'(m1a), int'(e.m1));
      if (e.mask[3]) chk(e.tag, "fwdBr0Id",  e.d2 ? int'(b0b) : int'(b0a), int'(e.b0));
      if (e.mask[4]) chk(e.tag, "fwdBr1Id",  e.d2 ? int'(b1b) : int'(b1a), int'(e.b1));
      if (e.mask[5]) chk(e.tag, "stallCnt",  e.d2 ? int'(sc2) : int'(sc1), e.sc);
    end
  end

  task automatic id(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d, input logic [5:0] f);
    nRs = a; nRt = b; nDst = d; nF = f;
  endtask

  task automatic step(input string tag, input bit d2, input bit [5:0] mask, input bit h,
                      input bit [1:0] m0, input bit [1:0] m1, input bit [1:0] b0,
                      input bit [1:0] b1, input int sc);
    exp_t r;
    @(posedge clk); #1;
    reset = nReset; rs = nRs; rt = nRt; dst = nDst;
    {ur, ut, rw, mr, br, fl} = nF;
    r.tag = tag; r.d2 = d2; r.mask = mask; r.h = h;
    r.m0 = m0; r.m1 = m1; r.b0 = b0; r.b1 = b1; r.sc = sc;
    expQ.push_back(r);
  endtask

  task automatic rst(input string tag, input bit d2);
    nReset = 1'b0; id(0, 0, 0, 6'd0);
    step({tag, "_held"}, d2, ALL, 0, 0, 0, 0, 0, 0);
    nReset = 1'b1;
    step({tag, "_rel"},  d2, ALL, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // L=1 ALU forwarding: MEM1 then WB
    rst("rst1", 0);
    id(1, 2, 3, UR|UT|RW); step("t1c1", 0, MH|M0|M1, 0, 0, 0, 0, 0, 0);
    id(3, 1, 4, UR|UT|RW); step("t1c2", 0, MH|M0|M1, 0, 0, 0, 0, 0, 0);
    id(1, 3, 5, UR|UT|RW); step("t1c3", 0, MH|M0|M1|B1, 0, 2, 0, 0, 2, 0);
    id(0, 0, 0, 6'd0);     step("t1c4", 0, MH|M0|M1, 0, 0, 1, 0, 0, 0);

    // L=1 load-use: one bubble, then WB forwarding on both operands
    rst("rst2", 0);
    id(1, 0, 5, UR|RW|MR); step("t2c1", 0, MH, 0, 0, 0, 0, 0, 0);
    id(5, 5, 6, UR|UT|RW); step("t2c2", 0, MH|MS, 1, 0, 0, 0, 0, 0);
                           step("t2c3", 0, MH|MS|M0|M1, 0, 0, 0, 0, 0, 1);
    id(0, 0, 0, 6'd0);     step("t2c4", 0, MH|M0|M1|MS, 0, 1, 1, 0, 0, 1);

    // L=2 load-use: two bubbles from EX, one from MEM1
    rst("rst3", 1);
    id(1, 0, 5, UR|RW|MR); step("t3c1", 1, MH, 0, 0, 0, 0, 0, 0);
    id(5, 1, 6, UR|UT|RW); step("t3c2", 1, MH|MS, 1, 0, 0, 0, 0, 0);
                           step("t3c3", 1, MH|MS, 1, 0, 0, 0, 0, 1);
                           step("t3c4", 1, MH|MS|M0, 0, 0, 0, 0, 0, 2);
    id(0, 0, 0, 6'd0);     step("t3c5", 1, MH|M0|M1|MS, 0, 1, 0, 0, 0, 2);
    id(1, 0, 5, UR|RW|MR); step("t3c6", 1, MH, 0, 0, 0, 0, 0, 0);
    id(0, 0, 0, 6'd0);     step("t3c7", 1, MH, 0, 0, 0, 0, 0, 0);
    id(5, 1, 6, UR|UT|RW); step("t3c8", 1, MH|MS, 1, 0, 0, 0, 0, 2);
                           step("t3c9", 1, MH|MS, 0, 0, 0, 0, 0, 3);

    // L=1 branch in ID: stall on ALU in EX, then MEM1 select; $0 never matches
    rst("rst4", 0);
    id(1, 2, 7, UR|UT|RW); step("t4c1", 0, MH, 0, 0, 0, 0, 0, 0);
    id(7, 0, 0, UR|UT|BR); step("t4c2", 0, MH|MS, 1, 0, 0, 0, 0, 0);
                           step("t4c3", 0, MH|MS|B0|B1, 0, 0, 0, 2, 0, 1);
    id(1, 0, 0, UR|RW);    step("t4c4", 0, MH, 0, 0, 0, 0, 0, 0);
    id(0, 0, 8, UR|UT|BR); step("t4c5", 0, MH|B0|B1, 0, 0, 0, 0, 0, 0);
    id(0, 0, 0, 6'd0);     step("t4c6", 0, M0|M1|MS, 0, 0, 0, 0, 0, 1);

    // flush beats a load-use stall
    rst("rst5", 0);
    id(1, 0, 5, UR|RW|MR);    step("t5c1", 0, MH, 0, 0, 0, 0, 0, 0);
    id(5, 5, 6, UR|UT|RW|FL); step("t5c2", 0, MH|MS, 0, 0, 0, 0, 0, 0);
    id(0, 0, 0, 6'd0);        step("t5c3", 0, MH|M0|M1|MS, 0, 0, 0, 0, 0, 0);

    // reset asserted in the middle of an L=2 stall
    rst("rst6", 1);
    id(1, 0, 5, UR|RW|MR); step("t6c1", 1, MH, 0, 0, 0, 0, 0, 0);
    id(5, 1, 6, UR|UT|RW); step("t6c2", 1, MH|MS, 1, 0, 0, 0, 0, 0);
                           step("t6c3", 1, MH|MS, 1, 0, 0, 0, 0, 1);
    nReset = 1'b0;         step("t6rst", 1, ALL, 0, 0, 0, 0, 0, 0);
    nReset = 1'b1;         step("t6rel", 1, ALL, 0, 0, 0, 0, 0, 0);

    // saturation with CNT_W=4: back-to-back dependent loads stall every other cycle
    rst("rst7", 0);
    id(5, 0, 5, UR|RW|MR);
    for (int i = 0; i < 42; i++)
      step("sat", 0, MH|MS, bit'(i % 2), 0, 0, 0, 0, (i / 2 > 15) ? 15 : i / 2);
    id(0, 0, 0, 6'd0);     step("satEnd", 0, MH|MS, 0, 0, 0, 0, 0, 15);

    repeat (3) @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      totalCnt++;
      $display("FAIL drain: %0d expectations left, expected 0", expQ.size());
    end
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
